// File: rtl/gobang_win_checker.sv
// Five-in-a-row detector driving a board datapath's line windows.
// Checks a single cell or scans the whole board row-major, reporting winner and board-full.
module gobang_win_checker #(
    parameter int BOARD_SIZE = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       single,
    input  logic [3:0] pos_i,
    input  logic [3:0] pos_j,
    output logic [3:0] consider_i,
    output logic [3:0] consider_j,
    input  logic [8:0] black_i,
    input  logic [8:0] black_j,
    input  logic [8:0] black_ij,
    input  logic [8:0] black_ji,
    input  logic [8:0] white_i,
    input  logic [8:0] white_j,
    input  logic [8:0] white_ij,
    input  logic [8:0] white_ji,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic       win_color,
    output logic [3:0] win_i,
    output logic [3:0] win_j,
    output logic       board_full
);

    localparam logic [3:0] LAST  = 4'(BOARD_SIZE - 1);
    localparam logic [7:0] CELLS = 8'(BOARD_SIZE * BOARD_SIZE);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t     state, state_nxt;
    logic       single_q;
    logic [7:0] occ_cnt;
    logic [7:0] occ_sum;
    logic       in_range;
    logic       black_hit;
    logic       white_hit;
    logic       hit;
    logic       last_cell;

    // Every 5-wide run inside a 9-wide window covers the centre bit.
    function automatic logic has_run5(input logic [8:0] w);
        logic r;
        r = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (&w[k +: 5]) r = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        in_range  = ({1'b0, consider_i} < 5'(BOARD_SIZE)) &&
                    ({1'b0, consider_j} < 5'(BOARD_SIZE));
        black_hit = in_range & (has_run5(black_i) | has_run5(black_j) |
                                has_run5(black_ij) | has_run5(black_ji));
        white_hit = in_range & (has_run5(white_i) | has_run5(white_j) |
                                has_run5(white_ij) | has_run5(white_ji));
        hit       = black_hit | white_hit;
        last_cell = (consider_i == LAST) && (consider_j == LAST);
        occ_sum   = occ_cnt + {7'd0, in_range & (black_i[4] | white_i[4])};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (hit || single_q || last_cell) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            single_q   <= 1'b0;
            occ_cnt    <= '0;
            consider_i <= '0;
            consider_j <= '0;
            win        <= 1'b0;
            win_color  <= 1'b0;
            win_i      <= '0;
            win_j      <= '0;
            board_full <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        single_q   <= single;
                        consider_i <= single ? pos_i : 4'd0;
                        consider_j <= single ? pos_j : 4'd0;
                        occ_cnt    <= '0;
                        win        <= 1'b0;
                        win_color  <= 1'b0;
                        win_i      <= '0;
                        win_j      <= '0;
                        board_full <= 1'b0;
                    end
                end
                SCAN: begin
                    occ_cnt <= occ_sum;
                    if (hit) begin
                        win       <= 1'b1;
                        win_color <= ~black_hit;
                        win_i     <= consider_i;
                        win_j     <= consider_j;
                    end else if (!single_q && !last_cell) begin
                        if (consider_j == LAST) begin
                            consider_j <= '0;
                            consider_i <= consider_i + 4'd1;
                        end else begin
                            consider_j <= consider_j + 4'd1;
                        end
                    end
                    if (state_nxt == DONE) begin
                        board_full <= (occ_sum == CELLS) & ~hit & ~single_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
